// File: rtl/cpu8_defs.sv
// Shared definitions for the cpu8 memory-mapped output port: data width,
// address map, control-register bit indices and the status byte layout.
package cpu8_defs;

   localparam int BW = 8;

   // Address map seen by the CPU
   localparam logic [7:0] ADDR_DATA   = 8'hF0;
   localparam logic [7:0] ADDR_STATUS = 8'hF1;
   localparam logic [7:0] ADDR_CTRL   = 8'hF2;

   // Control register bit indices
   localparam int CTRL_CLR_OVF = 0;
   localparam int CTRL_FLUSH   = 1;

   // Status byte, MSB first: {ovf, full, empty, count[4:0]}
   typedef struct packed {
      logic       ovf;
      logic       full;
      logic       empty;
      logic [4:0] count;
   } status_t;

endpackage

// File: rtl/cpu8_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata whenever the FIFO is non-empty; a flush clears pointers and count.
module cpu8_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A pop of an empty FIFO is meaningless; a push into a full FIFO is only
   // legal when the head leaves in the same cycle. Flush overrides both.
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & (~full | pop_ok) & ~flush;

   // Head byte is forced to zero while empty so no stale data is presented.
   assign rdata = empty ? '0 : mem[rd_ptr];

   // Storage write; contents are only meaningful below count.
   // NOTE: the memory array is deliberately not reset -- pointers and count
   // define validity, and a resettable array would cost a flop per bit.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
   // NOTE: non-blocking assignments keep every register reading pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu8_out_port.sv
// Memory-mapped output port for cpu8. Bytes written to the data address are
// queued in a FWFT FIFO and drained over valid/ready; the status byte is
// returned on rdata one cycle after it is addressed. Overflow is sticky until
// cleared through the control register, which can also flush the queue.
module cpu8_out_port
   import cpu8_defs::*;
#(
   parameter int            bw          = BW,
   parameter int            DEPTH       = 4,
   parameter logic [bw-1:0] DATA_ADDR   = bw'(ADDR_DATA),
   parameter logic [bw-1:0] STATUS_ADDR = bw'(ADDR_STATUS),
   parameter logic [bw-1:0] CTRL_ADDR   = bw'(ADDR_CTRL)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [bw-1:0] addr,
   input  logic [bw-1:0] wdata,
   input  logic          wr,
   output logic [bw-1:0] rdata,
   output logic [bw-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          full,
   output logic          ovf
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          sel_data;
   logic          sel_ctrl;
   logic          flush;
   logic          clr_ovf;
   logic          pop;
   logic          push;
   logic          drop;
   logic          empty;
   logic [CW-1:0] count;
   status_t       status;

   // Address decode and handshake qualification
   assign sel_data = wr & (addr == DATA_ADDR);
   assign sel_ctrl = wr & (addr == CTRL_ADDR);
   assign flush    = sel_ctrl & wdata[CTRL_FLUSH];
   assign clr_ovf  = sel_ctrl & wdata[CTRL_CLR_OVF];
   assign pop      = out_valid & out_ready & ~flush;
   assign push     = sel_data & (~full | pop);
   assign drop     = sel_data & full & ~pop;

   assign out_valid = ~empty;

   cpu8_fifo #(
      .W     (bw),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wdata),
      .rdata (out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Assemble the status byte from current (pre-edge) state.
   // NOTE: every field is assigned on every pass, so no latch can be inferred.
   always_comb begin
      status       = '0;
      status.ovf   = ovf;
      status.full  = full;
      status.empty = empty;
      status.count = 5'(count);
   end

   // Sticky overflow flag; an explicit clear beats a same-cycle drop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf <= 1'b0;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end
   end

   // Registered read-back path: status when addressed, zero otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata <= '0;
      end else begin
         rdata <= (addr == STATUS_ADDR) ? bw'(status) : '0;
      end
   end

endmodule

// File: tb/tb_cpu8_out_port.sv
// Directed testbench for cpu8_out_port: reset, FWFT drain, overflow,
// full-with-pop, flush/clear with pointer wrap, and reset mid-drain.
module tb_cpu8_out_port;

   logic       clk;
   logic       rstn;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       wr;
   logic [7:0] rdata;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       full;
   logic       ovf;

   int n_cmp = 0;
   int n_err = 0;

   cpu8_out_port dut (
      .clk       (clk),
      .rstn      (rstn),
      .addr      (addr),
      .wdata     (wdata),
      .wr        (wr),
      .rdata     (rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      tick();
      wr    = 1'b0;
      addr  = 8'h00;
      wdata = 8'h00;
   endtask

   // Address the status register for one edge; rdata is valid afterwards.
   task automatic cpu_read_status();
      addr = 8'hF1;
      wr   = 1'b0;
      tick();
      addr = 8'h00;
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      wr        = 1'b0;
      addr      = 8'h00;
      wdata     = 8'h00;
      rstn      = 1'b0;
      #12;
      n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", out_data); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      rstn = 1'b1;
      tick();
      cpu_read_status();
      n_cmp++; if (rdata !== 8'h20) begin n_err++; $display("FAIL reset_status got=%h exp=20", rdata); end
      tick();
      n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rdata_unaddressed got=%h exp=00", rdata); end
   endtask

   task automatic test_push_drain();
      logic [7:0] exp_q [3] = '{8'h11, 8'h22, 8'h33};
      out_ready = 1'b0;
      foreach (exp_q[i]) cpu_write(8'hF0, exp_q[i]);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL push_valid got=%b exp=1", out_valid); end
      n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL push_head got=%h exp=11", out_data); end
      cpu_read_status();
      n_cmp++; if (rdata !== 8'h03) begin n_err++; $display("FAIL push_status got=%h exp=03", rdata); end
      out_ready = 1'b1;
      foreach (exp_q[i]) begin
         n_cmp++; if (out_data !== exp_q[i] || out_valid !== 1'b1) begin
            n_err++; $display("FAIL drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, exp_q[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      out_ready = 1'b0;
      foreach (exp_q[i]) cpu_write(8'hF0, exp_q[i]);
      n_cmp++; if (full !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL fill4 full/ovf got=%b/%b exp=1/0", full, ovf); end
      cpu_write(8'hF0, 8'h05);
      n_cmp++; if (full !== 1'b1 || ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set full/ovf got=%b/%b exp=1/1", full, ovf); end
      cpu_read_status();
      n_cmp++; if (rdata !== 8'hC4) begin n_err++; $display("FAIL ovf_status got=%h exp=C4", rdata); end
      out_ready = 1'b1;
      foreach (exp_q[i]) begin
         n_cmp++; if (out_data !== exp_q[i] || out_valid !== 1'b1) begin
            n_err++; $display("FAIL ovf_drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, exp_q[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain_end got=%b exp=0", out_valid); end
      cpu_write(8'hF2, 8'h01);
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
   endtask

   task automatic test_full_pop();
      logic [7:0] fill_q [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
      logic [7:0] exp_q  [4] = '{8'h06, 8'h07, 8'h08, 8'hAA};
      out_ready = 1'b0;
      foreach (fill_q[i]) cpu_write(8'hF0, fill_q[i]);
      out_ready = 1'b1;
      cpu_write(8'hF0, 8'hAA);
      out_ready = 1'b0;
      n_cmp++; if (ovf !== 1'b0 || full !== 1'b1) begin n_err++; $display("FAIL fullpop ovf/full got=%b/%b exp=0/1", ovf, full); end
      n_cmp++; if (out_data !== 8'h06) begin n_err++; $display("FAIL fullpop_head got=%h exp=06", out_data); end
      cpu_read_status();
      n_cmp++; if (rdata !== 8'h44) begin n_err++; $display("FAIL fullpop_status got=%h exp=44", rdata); end
      out_ready = 1'b1;
      foreach (exp_q[i]) begin
         n_cmp++; if (out_data !== exp_q[i] || out_valid !== 1'b1) begin
            n_err++; $display("FAIL fullpop_drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, exp_q[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      logic [7:0] wrap_q [4] = '{8'h51, 8'h52, 8'h53, 8'h54};
      out_ready = 1'b0;
      cpu_write(8'hF0, 8'h41);
      cpu_write(8'hF0, 8'h42);
      cpu_write(8'hF0, 8'h43);
      cpu_write(8'hF0, 8'h44);
      cpu_write(8'hF0, 8'h45);
      out_ready = 1'b1;
      tick();
      // Three entries and ovf=1; pop requested during the flush must be ignored.
      cpu_write(8'hF2, 8'h03);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || ovf !== 1'b0 || full !== 1'b0) begin
         n_err++; $display("FAIL flush valid/ovf/full got=%b/%b/%b exp=0/0/0", out_valid, ovf, full);
      end
      cpu_read_status();
      n_cmp++; if (rdata !== 8'h20) begin n_err++; $display("FAIL flush_status got=%h exp=20", rdata); end
      // Refill to full so the write pointer wraps, then drain in order.
      foreach (wrap_q[i]) cpu_write(8'hF0, wrap_q[i]);
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL wrap_full got=%b exp=1", full); end
      out_ready = 1'b1;
      foreach (wrap_q[i]) begin
         n_cmp++; if (out_data !== wrap_q[i]) begin
            n_err++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, out_data, wrap_q[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      cpu_write(8'hF0, 8'h55);
      n_cmp++; if (out_data !== 8'h55 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL wrap_push got=%h/%b exp=55/1", out_data, out_valid);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_pop got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_drain();
      out_ready = 1'b0;
      cpu_write(8'hF0, 8'h61);
      cpu_write(8'hF0, 8'h62);
      cpu_write(8'hF0, 8'h63);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_data !== 8'h62) begin n_err++; $display("FAIL middrain_head got=%h exp=62", out_data); end
      #2;
      rstn = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || full !== 1'b0) begin
         n_err++; $display("FAIL async_reset valid/full got=%b/%b exp=0/0", out_valid, full);
      end
      #3;
      rstn = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         n_err++; $display("FAIL post_reset got=%b/%h exp=0/00", out_valid, out_data);
      end
      cpu_read_status();
      n_cmp++; if (rdata !== 8'h20) begin n_err++; $display("FAIL post_reset_status got=%h exp=20", rdata); end
      cpu_write(8'hF0, 8'h77);
      n_cmp++; if (out_data !== 8'h77) begin n_err++; $display("FAIL post_reset_push got=%h exp=77", out_data); end
   endtask

   // Watchdog: the sequence is tick-bounded, this only guards against a stall.
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_push_drain();
      test_overflow();
      test_full_pop();
      test_flush();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
